// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The optional auto-repeat feature is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    // is_key=0 means NONE; code is kept at zero for NONE so results compare directly
    typedef struct packed {
        logic      is_key;
        key_code_t code;
    } frame_result_t;

    localparam frame_result_t RESULT_NONE = '{is_key: 1'b0, code: 4'd0};
    localparam logic [3:0]    COL_RESET   = 4'b1110;

    // lows[col*4+row] set means that row read low while that column was driven
    function automatic frame_result_t decode_frame(input logic [15:0] lows);
        frame_result_t res;
        logic [4:0]    ones;
        key_code_t     idx;
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (lows[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
        res = RESULT_NONE;
        if (ones == 5'd1) begin
            res.is_key = 1'b1;
            res.code   = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Whole-frame debouncer: candidate/run tracking, stable state and event pulse.
// With KEYPAD_REPEAT_EN defined, a held key re-emits its code every REPEAT_FRAMES frames.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_valid,
    input  frame_result_t frame_result,
    output logic          event_valid,
    output key_code_t     event_code
);

    localparam int                RUN_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(DEBOUNCE_CNT);

    generate
        if (DEBOUNCE_CNT < 1 || REPEAT_FRAMES < 1) begin : g_param_check
            $error("key_debounce: DEBOUNCE_CNT and REPEAT_FRAMES must be at least 1");
        end
    endgenerate

    frame_result_t    cand_reg, cand_next;
    frame_result_t    stable_reg, stable_next;
    logic [RUN_W-1:0] run_reg, run_next;

`ifdef KEYPAD_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_FRAMES - 1);

    logic [RPT_W-1:0] rpt_reg, rpt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_reg <= '0;
        end else begin
            rpt_reg <= rpt_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_reg   <= RESULT_NONE;
            run_reg    <= '0;
            stable_reg <= RESULT_NONE;
        end else begin
            cand_reg   <= cand_next;
            run_reg    <= run_next;
            stable_reg <= stable_next;
        end
    end

    always_comb begin
        cand_next   = cand_reg;
        run_next    = run_reg;
        stable_next = stable_reg;
        event_valid = 1'b0;
        event_code  = '0;
`ifdef KEYPAD_REPEAT_EN
        rpt_next    = rpt_reg;
`endif
        if (frame_valid) begin
            if (frame_result == cand_reg) begin
                if (run_reg != RUN_MAX) begin
                    run_next = run_reg + 1'b1;
                end
            end else begin
                cand_next = frame_result;
                run_next  = RUN_W'(1);
            end
            // A release (stable -> NONE) updates state but never raises an event
            if (run_next == RUN_MAX && cand_next != stable_reg) begin
                stable_next = cand_next;
                event_valid = cand_next.is_key;
                event_code  = cand_next.code;
            end
`ifdef KEYPAD_REPEAT_EN
            if (stable_next != stable_reg) begin
                rpt_next = '0;
            end else if (stable_reg.is_key) begin
                if (rpt_reg == RPT_LAST) begin
                    rpt_next    = '0;
                    event_valid = 1'b1;
                    event_code  = stable_reg.code;
                end else begin
                    rpt_next = rpt_reg + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, frame decode and event register.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key (see key_debounce).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int DEBOUNCE_CNT  = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_overrun
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    generate
        if (SCAN_DIV < 4) begin : g_param_check
            $error("keypad_scanner: SCAN_DIV must be at least 4");
        end
    endgenerate

    logic [3:0]       row_meta_reg, row_sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       col_idx_reg;
    logic [3:0]       col_n_reg;
    logic [11:0]      held_lows;
    logic             sample_tick, frame_end;
    logic [15:0]      frame_lows;
    frame_result_t    frame_result;
    logic             ev_valid;
    key_code_t        ev_code;
    key_code_t        key_code_reg;
    logic             key_valid_reg, key_overrun_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign sample_tick = (cnt_reg == CNT_LAST);
    assign frame_end   = sample_tick && (col_idx_reg == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            col_idx_reg <= '0;
            col_n_reg   <= COL_RESET;
        end else if (sample_tick) begin
            cnt_reg     <= '0;
            col_idx_reg <= col_idx_reg + 2'd1;
            col_n_reg   <= {col_n_reg[2:0], col_n_reg[3]};
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Columns 0..2 are latched; column 3 is taken live on the frame-end cycle
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_col
            logic [3:0] lows_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lows_reg <= '0;
                end else if (sample_tick && col_idx_reg == 2'(gi)) begin
                    lows_reg <= ~row_sync_reg;
                end
            end
            assign held_lows[gi*4 +: 4] = lows_reg;
        end
    endgenerate

    assign frame_lows   = {~row_sync_reg, held_lows};
    assign frame_result = decode_frame(frame_lows);

    key_debounce #(
        .DEBOUNCE_CNT  (DEBOUNCE_CNT),
        .REPEAT_FRAMES (REPEAT_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_end),
        .frame_result (frame_result),
        .event_valid  (ev_valid),
        .event_code   (ev_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_reg    <= '0;
            key_valid_reg   <= 1'b0;
            key_overrun_reg <= 1'b0;
        end else if (key_valid_reg && key_ready) begin
            key_valid_reg   <= ev_valid;
            key_overrun_reg <= 1'b0;
            if (ev_valid) begin
                key_code_reg <= ev_code;
            end
        end else if (ev_valid) begin
            if (!key_valid_reg) begin
                key_code_reg  <= ev_code;
                key_valid_reg <= 1'b1;
            end else begin
                key_overrun_reg <= 1'b1;
            end
        end
    end

    assign col_n       = col_n_reg;
    assign key_code    = key_code_reg;
    assign key_valid   = key_valid_reg;
    assign key_overrun = key_overrun_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level reference model plus directed and random stimulus.
module tb_keypad_scanner;

    localparam int D     = 3;
    localparam int FRAME = 16;
    localparam int NONE  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n, row_n, key_code;
    logic        key_valid, key_ready, key_overrun;
    logic [15:0] mask;

    int errors = 0;
    int checks = 0;

    // reference model state
    int   n_edges;
    int   cyc = 0;
    int   hist[$];
    int   m_stable;
    logic m_valid, m_overrun;
    int   m_code;
    int   rises = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_CNT  (D),
        .REPEAT_FRAMES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .col_n       (col_n),
        .row_n       (row_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_overrun (key_overrun)
    );

    // keypad matrix: a pressed key shorts its row to the driven column
    always @* begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_n[c])
                for (int r = 0; r < 4; r++)
                    if (mask[c*4+r]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_of(input logic [15:0] m);
        int idx = NONE;
        if ($countones(m) == 1)
            for (int i = 0; i < 16; i++) if (m[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        n_edges   = 0;
        hist.delete();
        m_stable  = NONE;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_code    = 0;
    endtask

    task automatic model_edge();
        bit ev = 0;
        int evc = 0;
        bit same;
        n_edges++;
        if (n_edges % FRAME == 0) begin
            hist.push_back(frame_of(mask));
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                same = 1;
                foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
                if (same && hist[0] != m_stable) begin
                    m_stable = hist[0];
                    if (m_stable != NONE) begin
                        ev  = 1;
                        evc = m_stable;
                    end
                end
            end
        end
        if (m_valid && key_ready) begin
            $display("txn: consumer accepted code=%0d at cycle %0d", m_code, cyc);
            m_valid   = ev;
            m_overrun = 1'b0;
            if (ev) m_code = evc;
        end else if (ev) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_code  = evc;
            end else begin
                $display("txn: event code=%0d dropped at cycle %0d", evc, cyc);
                m_overrun = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] exp_col();
        logic [3:0] e = 4'hF;
        e[(n_edges / 4) % 4] = 1'b0;
        return e;
    endfunction

    // compare process: outputs checked against the model one step after every edge
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) model_reset();
            else     model_edge();
            check("col_n", col_n, exp_col());
            check("key_valid", key_valid, m_valid);
            check("key_overrun", key_overrun, m_overrun);
            check("key_code", key_code, m_code);
            if (key_valid && !prev_valid) rises++;
            prev_valid = key_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic align();
        int k = 0;
        while (n_edges % FRAME != 0 && k < 40) begin
            tick();
            k++;
        end
        if (n_edges % FRAME != 0) check("frame_align", n_edges % FRAME, 0);
    endtask

    task automatic frames(input int k, input logic [15:0] m);
        align();
        mask = m;
        repeat (FRAME * k) tick();
    endtask

    task automatic handshake();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pats [4];
        int r0, t0, k;
        logic [15:0] m;
        pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        mask = '0;
        key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // scan sequence with no keys
        for (int i = 0; i < 16; i++) begin
            check("scan_col", col_n, pats[i/4]);
            tick();
        end
        repeat (84) tick();
        check("idle_no_valid", key_valid, 0);
        check("idle_no_rise", rises, 0);

        // single press of column 1, row 2
        align();
        r0 = rises;
        mask = 16'h1 << 6;
        t0 = cyc;
        k = 0;
        while (!key_valid && k < 80) begin
            tick();
            k++;
        end
        check("press_latency", cyc - t0, 48);
        check("press_code", key_code, 6);
        check("model_press_code", m_code, 6);
        while (cyc - t0 < 5 * FRAME) tick();
        frames(4, 16'h0);
        check("press_one_event", rises - r0, 1);
        check("press_no_overrun", key_overrun, 0);
        handshake();
        check("press_cleared", key_valid, 0);

        // bounce then settle
        frames(4, 16'h0);
        r0 = rises;
        for (int i = 0; i < 6; i++) frames(1, (i % 2 == 0) ? (16'h1 << 6) : 16'h0);
        check("bounce_no_event", rises - r0, 0);
        frames(3, 16'h1 << 6);
        check("bounce_event", rises - r0, 1);
        check("bounce_code", key_code, 6);
        handshake();
        frames(4, 16'h0);

        // ghost: rows 0 and 3 low in column 2
        r0 = rises;
        frames(5, (16'h1 << 8) | (16'h1 << 11));
        check("ghost_no_event", rises - r0, 0);
        check("model_ghost_stable", m_stable, NONE);
        frames(4, 16'h0);

        // overrun
        frames(4, 16'h1);
        check("ovr_first_valid", key_valid, 1);
        frames(4, 16'h0);
        frames(4, 16'h8000);
        check("ovr_code_kept", key_code, 0);
        check("ovr_flag", key_overrun, 1);
        check("model_ovr_flag", m_overrun, 1);
        handshake();
        check("ovr_valid_cleared", key_valid, 0);
        check("ovr_flag_cleared", key_overrun, 0);
        frames(4, 16'h0);

        // reset in column 2 with an event pending
        frames(4, 16'h1 << 5);
        check("rst_pre_valid", key_valid, 1);
        k = 0;
        while ((n_edges / 4) % 4 != 2 && k < 20) begin
            tick();
            k++;
        end
        #1 rst = 1'b1;
        #1;
        check("rst_col", col_n, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_overrun", key_overrun, 0);
        repeat (2) tick();
        rst = 1'b0;
        r0 = rises;
        k = 0;
        while (!key_valid && k < 100) begin
            tick();
            k++;
        end
        check("rst_fresh_event", rises - r0, 1);
        check("rst_fresh_code", key_code, 5);
        handshake();
        frames(4, 16'h0);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            int kind = $urandom % 4;
            int a = $urandom % 16;
            int b = (a + 1 + ($urandom % 15)) % 16;
            int len = 1 + ($urandom % 4);
            m = '0;
            if (kind == 1 || kind == 2) m[a] = 1'b1;
            if (kind == 3) begin
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
            align();
            mask = m;
            for (int c = 0; c < FRAME * len; c++) begin
                key_ready = ($urandom % 3 == 0);
                tick();
            end
        end
        key_ready = 1'b0;
        mask = '0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Multiplexed 4x4 matrix keypad scanner: the input-side counterpart of the stopwatch's multiplexed seven-segment display driver. It drives one active-low column at a time, samples the active-low rows, debounces whole-frame results, and delivers key-press events as a 4-bit code over a valid/ready handshake. It sits beside the display path in the top level and feeds the counter and control logic.

## Interface
- SCAN_DIV, 1000: clk cycles per column period; must be at least 4.
- DEBOUNCE_CNT, 4: consecutive identical frame results needed to accept a new stable state; must be at least 1.
- REPEAT_FRAMES, 64: frames between auto-repeat events; used only with `KEYPAD_REPEAT_EN`.
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- col_n  out  4  column drive, one-hot-low; `1110` drives column 0.
- row_n  in  4  row sense, pulled up; a low bit means pressed in the driven column. Asynchronous to clk.
- key_code  out  4  code = col*4 + row, valid while key_valid is high.
- key_valid  out  1  an event is pending.
- key_ready  in  1  consumer accepts the event.
- key_overrun  out  1  sticky flag: an event was dropped.

## Operation
- **Row synchroniser:** row_n passes through a 2-flop synchroniser.
- **Column period:**
  - A counter runs 0 to SCAN_DIV-1 per column.
  - The synchronised rows are sampled at count SCAN_DIV-1.
  - col_n then rotates left, so column 0 to 1 to 2 to 3 to 0.
- **Frame:** four column periods, columns 0 to 3.
- **Frame result**, evaluated once at the end of column 3:
  - NONE: no sampled low bits.
  - KEY(c,r): exactly one low bit in the whole frame.
  - NONE also when more than one bit is low. Ghost and multi-key frames are discarded.
- **Debounce:**
  - Track the candidate as the last frame result, plus a run counter.
  - If the result equals the candidate, the run increments, saturating at DEBOUNCE_CNT. Otherwise the candidate becomes the result and the run is 1.
  - When the run reaches DEBOUNCE_CNT and the candidate differs from the stable state, the stable state becomes the candidate.
- **Events:**
  - A stable transition to KEY(c,r) from NONE or from a different key generates an event with code c*4+r.
  - A transition to NONE generates no event.
- **Output register:**
  - If an event arrives while key_valid=0, load key_code and set key_valid.
  - If an event arrives while key_valid=1, the event is dropped, key_code is unchanged, and key_overrun is set.
  - On a handshake (key_valid && key_ready), clear key_valid and key_overrun. If an event arrives in the same cycle, load the new event, set key_valid, and leave key_overrun cleared.
- **Reset values:**
  - col_n=`1110`, key_code=0, key_valid=0, key_overrun=0.
  - All counters 0; candidate and stable state are NONE.
  - Reset mid-frame abandons the frame; scanning restarts at column 0, count 0, on the first clk after rst falls.

## Timing
- A column is driven for SCAN_DIV cycles, so rows settle for SCAN_DIV-3 cycles after synchroniser delay before the sample.
- The frame end is the sample cycle of column 3.
- key_valid rises on the clk edge after the frame end at which the debounce run reaches DEBOUNCE_CNT.
- Latency from a clean press to key_valid is at most (DEBOUNCE_CNT+1)*4*SCAN_DIV+3 cycles.
- key_valid and key_code are registered and hold steady until the handshake. key_valid falls on the edge after the handshake cycle.
- key_ready is ignored while key_valid=0.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - While the stable state is KEY, a frame counter runs.
  - Every REPEAT_FRAMES frames after acceptance, the same code is re-emitted as an event, subject to the same overrun rules.
  - The counter clears when the stable state changes.
- **Undefined:** each press yields exactly one event, and REPEAT_FRAMES is unused.

## Structure
- Shared package `keypad_pkg` holds:
  - a typedef `key_code_t` (4 bits);
  - a typedef `frame_result_t` for NONE or a key code;
  - the NONE constant;
  - the column reset pattern `1110`.
- One sub-module, `key_debounce`: frame-result candidate, run counter and stable state, outputting a one-cycle event pulse with its code. Scanning, the synchroniser and the output register stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3, so a frame is 16 cycles.
- **Reset and scan:** release rst, with row_n=`1111` throughout.
  - col_n steps `1110`, `1101`, `1011`, `0111`, changing every 4 cycles.
  - key_valid stays 0 for 100 cycles.
- **Single press:** row 2 pulled low only while column 1 is driven, for 5 frames, key_ready=0.
  - key_valid rises within 67 cycles of the first affected frame.
  - key_code=6.
  - Exactly one event.
- **Bounce:** the press alternates present and absent every frame for 6 frames, then is held for 3 frames.
  - No event during the bounce.
  - One event after the 3rd stable frame.
- **Ghosting:** rows 0 and 3 are low in column 2 for 5 frames.
  - No event is produced.
- **Overrun:** key 0 is pressed, released for 4 frames, then key 15 is pressed, with key_ready=0.
  - key_code stays 0 and key_overrun=1.
  - Asserting key_ready for 1 cycle clears both key_valid and key_overrun.
- **Reset mid-operation:** assert rst during column 2 while key_valid=1.
  - Immediately col_n=`1110`, key_valid=0, key_overrun=0.
  - With the key still held after release, one fresh event arrives after debounce.
